rgb_stream_capture: RTL

Captures the parallel RGB video stream (rgb, rgb_clk, hsync, vsync) into the 16-bit slice RAM as RGB565 pixels. It replaces the RAM stand-in in front of the framebuffer. The block runs in the clock_66 domain, oversamples the slow pixel clock and double-buffers whole frames in two RAM banks. It signals the framebuffer through stream_ready and read_bank once a complete frame is available.

---
 rtl/rgb_capture_pkg.sv | 13 +
 rtl/sync_edge.sv | 31 +++
 rtl/rgb_stream_capture.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rgb_capture_pkg.sv
// Shared types and helpers for the RGB stream capture block.
package rgb_capture_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {IDLE, ALIGN, CAPTURE} state_t;

  // Truncating 888 -> 565 pack, {R[7:3], G[7:2], B[7:3]}.
  function automatic logic [15:0] to_rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with registered level and rise/fall pulses, all aligned.
module sync_edge
  import rgb_capture_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clock_66,
  input  logic             nrst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] lvl,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      lvl    <= '0;
      rise   <= '0;
      fall   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      lvl    <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~lvl;
      fall   <= ~sync_q[SYNC_STAGES-1] & lvl;
    end
  end

endmodule

// File: rtl/rgb_stream_capture.sv
// Oversampled RGB888 video capture into two RAM banks as RGB565, frame double-buffered.
module rgb_stream_capture
  import rgb_capture_pkg::*;
#(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BANK_SIZE = H_ACTIVE * V_ACTIVE
) (
  input  logic        clock_66,
  input  logic        nrst,
  input  logic        enable,
  input  logic        rgb_clk,
  input  logic [23:0] rgb,
  input  logic        hsync,
  input  logic        vsync,
  output logic [31:0] ram_waddr,
  output logic [15:0] ram_wdata,
  output logic        w_enable,
  output logic        stream_ready,
  output logic        read_bank,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  // bit 0 rgb_clk, bit 1 hsync, bit 2 vsync
  logic [2:0] sig_in, sig_lvl, sig_rise, sig_fall;
  assign sig_in = {vsync, hsync, rgb_clk};

  for (genvar i = 0; i < 3; i++) begin : g_sync
    sync_edge #(.WIDTH(1)) u_sync (
      .clock_66 (clock_66),
      .nrst     (nrst),
      .din      (sig_in[i]),
      .lvl      (sig_lvl[i]),
      .rise     (sig_rise[i]),
      .fall     (sig_fall[i])
    );
  end

  logic unused_sync;
  assign unused_sync = |{sig_lvl[0], sig_fall[1:0]};

  logic [SYNC_STAGES-1:0][23:0] rgb_q;

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) rgb_q <= '0;
    else       rgb_q <= {rgb_q[SYNC_STAGES-2:0], rgb};
  end

  state_t          state, state_nxt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [31:0]     line_addr;
  logic            wbank;
  logic            wr_px, line_end, frame_ok, frame_bad, align_go;

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame end wins over line end; any sync level masks the pixel event.
  always_comb begin
    state_nxt = state;
    wr_px     = 1'b0;
    line_end  = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    align_go  = 1'b0;
    if (!enable) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:  state_nxt = ALIGN;
        ALIGN: if (sig_fall[2]) begin
          align_go  = 1'b1;
          state_nxt = CAPTURE;
        end
        CAPTURE: begin
          if (sig_rise[2]) begin
            state_nxt = ALIGN;
            if (y == YW'(V_ACTIVE)) frame_ok  = 1'b1;
            else                    frame_bad = 1'b1;
          end else if (sig_rise[1]) begin
            line_end = 1'b1;
          end else if (sig_rise[0] && !sig_lvl[1] && !sig_lvl[2] &&
                       x < XW'(H_ACTIVE) && y < YW'(V_ACTIVE)) begin
            wr_px = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_66 or negedge nrst) begin
    if (!nrst) begin
      x            <= '0;
      y            <= '0;
      line_addr    <= '0;
      wbank        <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      w_enable     <= 1'b0;
      stream_ready <= 1'b0;
      read_bank    <= 1'b0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      w_enable   <= wr_px;
      frame_done <= frame_ok;
      if (state_nxt == IDLE) begin
        x <= '0;
        y <= '0;
      end
      if (align_go) begin
        x         <= '0;
        y         <= '0;
        line_addr <= wbank ? 32'(BANK_SIZE) : 32'd0;
      end
      if (wr_px) begin
        ram_waddr <= line_addr + 32'(x);
        ram_wdata <= to_rgb565(rgb_q[SYNC_STAGES-1]);
        x         <= x + 1'b1;
      end
      // line_addr tracks wbank*BANK_SIZE + y*H_ACTIVE without a multiplier
      if (line_end) begin
        x <= '0;
        if (x != '0 && y != YW'(V_ACTIVE)) begin
          y         <= y + 1'b1;
          line_addr <= line_addr + 32'(H_ACTIVE);
        end
      end
      if (frame_ok) begin
        read_bank    <= wbank;
        wbank        <= ~wbank;
        stream_ready <= 1'b1;
      end
      if (frame_bad) frame_error <= 1'b1;
    end
  end

endmodule
